// File: rtl/imm_decode_pkg.sv
// Shared types and opcode constants for the immediate decode stage.
package imm_decode_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;

  // Immediate format reported alongside each decoded instruction
  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_U    = 3'd3,
    FMT_J    = 3'd4,
    FMT_NONE = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_FENCE   = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_OP32    = 7'b0111011;

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the immediate decode stage.
// slave: the decode stage; master: the surrounding pipeline.
interface imm_decode_stage_if
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  imm_fmt_e          out_fmt;
  logic              out_illegal;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

endinterface

// File: rtl/imm_decode_comb.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Optional macro IMM_DECODE_ZICSR_EN: CSR immediate forms report FMT_Z.
module imm_decode_comb
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   imm_c,
  output imm_fmt_e          fmt_c,
  output logic              illegal_c
);

  localparam bit IS_RV64 = (XLEN == 64);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
    $error("imm_decode_comb: XLEN must be 32 or 64, got %0d", XLEN);
  end

  logic [OPC_W-1:0] opc;
  logic [31:0]      imm_i;
  logic [31:0]      imm_s;
  logic [31:0]      imm_b;
  logic [31:0]      imm_u;
  logic [31:0]      imm_j;

  assign opc = inst[OPC_W-1:0];

  // 32-bit candidates whose bit 31 is always inst[31]; widened to XLEN below
  assign imm_i = 32'($signed(inst[31:20]));
  assign imm_s = 32'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Opcode table; anything unlisted is flagged illegal with a zero immediate
  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_NONE;
    illegal_c = 1'b0;
    if (inst[1:0] != 2'b11) begin
      illegal_c = 1'b1;
    end else begin
      unique case (opc)
        OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
          fmt_c = FMT_I;
          imm_c = sext32(imm_i);
        end
        OPC_STORE: begin
          fmt_c = FMT_S;
          imm_c = sext32(imm_s);
        end
        OPC_BRANCH: begin
          fmt_c = FMT_B;
          imm_c = sext32(imm_b);
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt_c = FMT_U;
          imm_c = sext32(imm_u);
        end
        OPC_JAL: begin
          fmt_c = FMT_J;
          imm_c = sext32(imm_j);
        end
        OPC_OP, OPC_FENCE: begin
          fmt_c = FMT_NONE;
        end
        OPC_SYSTEM: begin
`ifdef IMM_DECODE_ZICSR_EN
          // ECALL/EBREAK (funct3=0) carry no immediate
          if (inst[14:12] != 3'b000) begin
            fmt_c = FMT_Z;
            if (inst[14]) imm_c = XLEN'(inst[19:15]);
          end
`else
          fmt_c = FMT_NONE;
`endif
        end
        OPC_OPIMM32: begin
          if (IS_RV64) begin
            fmt_c = FMT_I;
            imm_c = sext32(imm_i);
          end else begin
            illegal_c = 1'b1;
          end
        end
        OPC_OP32: begin
          if (!IS_RV64) illegal_c = 1'b1;
        end
        default: illegal_c = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage with a 2-entry skid buffer between
// fetch and execute. in_ready is a pure register output (= !skid_valid).
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_decode_stage_if.slave   bus
);

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  logic             in_ready_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_imm_q;
  imm_fmt_e         out_fmt_q;
  logic             out_illegal_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             skid_valid_q;
  logic [XLEN-1:0]  skid_imm_q;
  imm_fmt_e         skid_fmt_q;
  logic             skid_illegal_q;
  logic [TAG_W-1:0] skid_tag_q;

  logic             accept;
  logic             out_free;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst      (bus.in_inst),
    .imm_c     (dec_imm),
    .fmt_c     (dec_fmt),
    .illegal_c (dec_illegal)
  );

  assign accept   = bus.in_valid && in_ready_q;
  assign out_free = !out_valid_q || bus.out_ready;

  // Output register and skid entry; skid always refills the output first
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
      skid_tag_q     <= '0;
    end else if (flush) begin
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_q   <= 1'b1;
        out_imm_q     <= skid_imm_q;
        out_fmt_q     <= skid_fmt_q;
        out_illegal_q <= skid_illegal_q;
        out_tag_q     <= skid_tag_q;
        skid_valid_q  <= 1'b0;
        in_ready_q    <= 1'b1;
      end else if (accept) begin
        out_valid_q   <= 1'b1;
        out_imm_q     <= dec_imm;
        out_fmt_q     <= dec_fmt;
        out_illegal_q <= dec_illegal;
        out_tag_q     <= bus.in_tag;
      end else begin
        out_valid_q   <= 1'b0;
      end
    end else if (accept) begin
      skid_valid_q   <= 1'b1;
      skid_imm_q     <= dec_imm;
      skid_fmt_q     <= dec_fmt;
      skid_illegal_q <= dec_illegal;
      skid_tag_q     <= bus.in_tag;
      in_ready_q     <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_illegal = out_illegal_q;
  assign bus.out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus
// and are compared each cycle against a 2-deep FIFO model plus a field-level
// arithmetic decoder.
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] tag;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_decode_stage_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_inst   = in_inst;
  assign bus32.in_tag    = in_tag;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_inst   = in_inst;
  assign bus64.in_tag    = in_tag;
  assign bus64.out_ready = out_ready;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus32)
  );
  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus64)
  );

  function automatic longint sx(input longint f, input int w);
    if (f >= (longint'(1) << (w - 1))) return f - (longint'(1) << w);
    return f;
  endfunction

  // Reference decoder built from field arithmetic
  function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                  output logic [63:0] imm, output logic [2:0] fmt,
                                  output logic ill);
    longint v;
    v   = 0;
    fmt = 3'd5;
    ill = 1'b0;
    case (i[6:0])
      7'h03, 7'h13, 7'h67: begin fmt = 3'd0; v = sx(longint'(i[31:20]), 12); end
      7'h1B: if (x64) begin fmt = 3'd0; v = sx(longint'(i[31:20]), 12); end
             else ill = 1'b1;
      7'h23: begin
        fmt = 3'd1;
        v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
      end
      7'h63: begin
        fmt = 3'd2;
        v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 +
               longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin fmt = 3'd3; v = sx(longint'(i[31:12]), 20) * 4096; end
      7'h6F: begin
        fmt = 3'd4;
        v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 +
               longint'(i[20]) * 2048 + longint'(i[30:21]) * 2, 21);
      end
      7'h33, 7'h0F: fmt = 3'd5;
      7'h3B: if (!x64) ill = 1'b1;
      7'h73: begin
`ifdef IMM_DECODE_ZICSR_EN
        if (i[14:12] != 3'd0) begin
          fmt = 3'd6;
          if (i[14]) v = longint'(i[19:15]);
        end
`endif
      end
      default: ill = 1'b1;
    endcase
    if (i[1:0] != 2'b11) begin
      ill = 1'b1;
      fmt = 3'd5;
      v   = 0;
    end
    imm = 64'(v);
    if (!x64) imm[63:32] = 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Compare both DUTs against the FIFO model state
  task automatic check_state(input string where);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    bit          e_rdy;
    bit          e_vld;
    e_rdy = (q.size() < 2);
    e_vld = (q.size() > 0);
    chk({where, ".rdy32"}, 64'(bus32.in_ready), 64'(e_rdy));
    chk({where, ".rdy64"}, 64'(bus64.in_ready), 64'(e_rdy));
    chk({where, ".vld32"}, 64'(bus32.out_valid), 64'(e_vld));
    chk({where, ".vld64"}, 64'(bus64.out_valid), 64'(e_vld));
    if (e_vld) begin
      ref_dec(q[0].inst, 1'b0, e_imm, e_fmt, e_ill);
      chk({where, ".imm32"}, 64'(bus32.out_imm), e_imm);
      chk({where, ".fmt32"}, 64'(bus32.out_fmt), 64'(e_fmt));
      chk({where, ".ill32"}, 64'(bus32.out_illegal), 64'(e_ill));
      chk({where, ".tag32"}, 64'(bus32.out_tag), 64'(q[0].tag));
      ref_dec(q[0].inst, 1'b1, e_imm, e_fmt, e_ill);
      chk({where, ".imm64"}, bus64.out_imm, e_imm);
      chk({where, ".fmt64"}, 64'(bus64.out_fmt), 64'(e_fmt));
      chk({where, ".ill64"}, 64'(bus64.out_illegal), 64'(e_ill));
      chk({where, ".tag64"}, 64'(bus64.out_tag), 64'(q[0].tag));
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge
  task automatic step(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
    bit          acc;
    bit          drn;
    logic [31:0] tg;
    tg        = $urandom;
    in_valid  = v;
    in_inst   = inst;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{inst: inst, tag: tg});
    end
    @(negedge clk);
    check_state("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_inst = 32'd0;
    in_tag = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    q.delete();
    chk("rst.rdy32", 64'(bus32.in_ready), 64'd1);
    chk("rst.vld32", 64'(bus32.out_valid), 64'd0);
    chk("rst.imm32", 64'(bus32.out_imm), 64'd0);
    chk("rst.fmt32", 64'(bus32.out_fmt), 64'd5);
    chk("rst.ill32", 64'(bus32.out_illegal), 64'd0);
    chk("rst.tag32", 64'(bus32.out_tag), 64'd0);
    chk("rst.vld64", 64'(bus64.out_valid), 64'd0);
    chk("rst.imm64", bus64.out_imm, 64'd0);
    chk("rst.tag64", 64'(bus64.out_tag), 64'd0);
    rst = 1'b0;
  endtask

  logic [6:0]  opcs [16];
  logic [31:0] r;
  logic [63:0] z_imm;
  logic [63:0] z_fmt;

  initial begin
    opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
             7'h33, 7'h0F, 7'h73, 7'h1B, 7'h3B, 7'h7F, 7'h02, 7'h5B};
`ifdef IMM_DECODE_ZICSR_EN
    z_imm = 64'd3;
    z_fmt = 64'd6;
`else
    z_imm = 64'd0;
    z_fmt = 64'd5;
`endif

    do_reset();

    // Single beats with sustained out_ready
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    chk("addi.imm", 64'(bus32.out_imm), 64'hFFFF_FFFF);
    chk("addi.fmt", 64'(bus32.out_fmt), 64'd0);
    chk("addi.ill", 64'(bus32.out_illegal), 64'd0);
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);
    chk("beq.imm", 64'(bus32.out_imm), 64'hFFFF_FFFC);
    chk("beq.fmt", 64'(bus32.out_fmt), 64'd2);

    // Back-to-back U, J, S
    step(1'b1, 32'h123450B7, 1'b1, 1'b0);
    chk("lui.imm", 64'(bus32.out_imm), 64'h1234_5000);
    chk("lui.rdy", 64'(bus32.in_ready), 64'd1);
    step(1'b1, 32'h0080006F, 1'b1, 1'b0);
    chk("jal.imm", 64'(bus32.out_imm), 64'd8);
    chk("jal.fmt", 64'(bus32.out_fmt), 64'd4);
    step(1'b1, 32'h00112023, 1'b1, 1'b0);
    chk("sw.imm", 64'(bus32.out_imm), 64'd0);
    chk("sw.fmt", 64'(bus32.out_fmt), 64'd1);
    chk("sw.rdy", 64'(bus32.in_ready), 64'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Stall: beat 1 in output, beat 2 in skid, beat 3 refused
    step(1'b1, 32'h00500093, 1'b0, 1'b0);
    step(1'b1, 32'hFFB00113, 1'b0, 1'b0);
    chk("hold.rdy", 64'(bus32.in_ready), 64'd0);
    step(1'b1, 32'h00C00193, 1'b0, 1'b0);
    step(1'b1, 32'h00C00193, 1'b0, 1'b0);
    chk("hold.front", 64'(bus32.out_imm), 64'd5);
    step(1'b1, 32'h00C00193, 1'b1, 1'b0);
    chk("drain.rdy", 64'(bus32.in_ready), 64'd1);
    step(1'b1, 32'h00C00193, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // RV64-specific encodings
    step(1'b1, 32'h800000B7, 1'b1, 1'b0);
    chk("lui64.imm", bus64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui32.imm", 64'(bus32.out_imm), 64'h8000_0000);
    step(1'b1, 32'h0010009B, 1'b1, 1'b0);
    chk("addiw64.imm", bus64.out_imm, 64'd1);
    chk("addiw64.fmt", 64'(bus64.out_fmt), 64'd0);
    chk("addiw32.ill", 64'(bus32.out_illegal), 64'd1);
    chk("addiw32.fmt", 64'(bus32.out_fmt), 64'd5);

    // CSR immediate form
    step(1'b1, 32'h3401D073, 1'b1, 1'b0);
    chk("csrrwi.fmt", 64'(bus32.out_fmt), z_fmt);
    chk("csrrwi.imm", 64'(bus32.out_imm), z_imm);
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Flush with skid full and an input offered in the flush cycle
    step(1'b1, 32'h00100093, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 1'b0, 1'b1);
    chk("flush.vld", 64'(bus32.out_valid), 64'd0);
    chk("flush.rdy", 64'(bus32.in_ready), 64'd1);
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    // Reset mid-stream
    step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    step(1'b1, 32'h123450B7, 1'b0, 1'b0);
    do_reset();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 15)];
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0);
    end
    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Pipelined, parametrised successor to the combinational immediate generator.
- Sits between fetch and execute in the pipelined core. Accepts one instruction per cycle over a valid/ready handshake.
- Outputs a registered XLEN-wide immediate, a format code, an illegal-opcode flag and a pass-through tag (normally the PC).
- A 2-entry skid buffer keeps full throughput while in_ready stays a pure register output.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64 only.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  sideband (PC).
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code (imm_fmt_e).
- out_illegal  out  1  unrecognised encoding.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, in_ready=1, skid empty, out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_tag=0.
- Handshake:
  - An input beat transfers when in_valid&&in_ready.
  - An output beat transfers when out_valid&&out_ready.
  - Payload stays stable while out_valid&&!out_ready.
- Latency: 1 cycle from accept to out_valid when both entries are empty.
- Skid buffer:
  - in_ready = !skid_valid, registered.
  - Accept while the output register is empty or draining: the new entry loads the output register.
  - Accept while the output register is held: the new entry goes to skid and in_ready drops next cycle.
  - When the output drains with skid full: skid moves to the output register and in_ready rises next cycle.
  - Sustained out_ready=1 gives 1 beat/cycle with no bubbles.
- Decode is combinational on in_inst and registered on accept. Rules:
  - inst[1:0]!=2'b11 → illegal=1, imm=0, fmt=NONE.
  - 0000011, 0010011, 1100111 → FMT_I: sext(inst[31:20]).
  - 0100011 → FMT_S: sext({inst[31:25],inst[11:7]}).
  - 1100011 → FMT_B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - 0110111, 0010111 → FMT_U: sext({inst[31:12],12'b0}), sign bit is inst[31]. This matters when XLEN=64.
  - 1101111 → FMT_J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
  - 0110011, 0001111, 1110011 → FMT_NONE, imm=0, legal.
  - XLEN=64 only: 0011011 → FMT_I; 0111011 → FMT_NONE.
  - Anything else (including 0011011/0111011 when XLEN=32) → illegal=1, imm=0, fmt=NONE.
- Sign extension always replicates inst[31] up to XLEN-1.
- Flush:
  - Clears out_valid and skid_valid next cycle and forces in_ready=1 next cycle.
  - An input presented in the flush cycle is dropped.
  - Flush takes priority over a simultaneous accept.
- Reset mid-stream: same effect as flush, and payload registers also return to their reset values.
- Illegal XLEN: elaboration error via $error.

Optional Feature:
- Macro: IMM_DECODE_ZICSR_EN.
- Defined: opcode 1110011 with funct3!=0 → FMT_Z.
  - funct3[2]=1: imm = zero-extended inst[19:15] (uimm).
  - funct3[2]=0: imm = 0.
  - funct3=0 (ECALL/EBREAK) remains FMT_NONE.
- Undefined: all 1110011 encodings → FMT_NONE, imm=0. FMT_Z is never produced.

Decomposition:
- Package imm_decode_pkg holds:
  - imm_fmt_e (3-bit): FMT_I=0, FMT_S=1, FMT_B=2, FMT_U=3, FMT_J=4, FMT_NONE=5, FMT_Z=6.
  - Opcode localparams: OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_FENCE, OPC_SYSTEM, OPC_OPIMM32, OPC_OP32.
- Sub-module imm_decode_comb: parametrised XLEN, purely combinational inst → {imm, fmt, illegal}.
- The top level holds only the skid and handshake logic.

Test Plan:
- XLEN=32, out_ready=1:
  - 0xFFF00093 → next cycle imm=0xFFFFFFFF, fmt=I, illegal=0.
  - 0xFE000EE3 → imm=0xFFFFFFFC, fmt=B.
- Back-to-back 0x123450B7, 0x0080006F, 0x00112023 with out_ready=1 → 3 consecutive out beats:
  - imm=0x12345000 (U), then 0x00000008 (J), then 0x00000000 (S).
  - in_ready stays 1 throughout.
- Hold out_ready=0 and push 3 beats:
  - Beat 1 sits in the output register, beat 2 in skid, in_ready=0 from the cycle after beat 2.
  - Beat 3 is not accepted.
  - Release out_ready: beats drain in order and in_ready returns to 1.
- XLEN=64:
  - 0x800000B7 → imm=0xFFFFFFFF80000000.
  - 0x0010009B (addiw) → fmt=I, imm=1.
  - The same addiw at XLEN=32 → illegal=1.
- Flush with skid full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the flush-cycle input is never emitted.
- IMM_DECODE_ZICSR_EN defined: 0x3401D073 (csrrwi) → fmt=Z, imm=3. Macro undefined: same input → fmt=NONE, imm=0.
